mcycle_control_unit: RTL

MCYCLE_CONTROL_UNIT -- requirements
Module: mcycle_control_unit

---
 rtl/mcycle_control_unit_if.sv | 37 +++
 rtl/mcycle_control_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_control_unit_if.sv
// Controller <-> datapath bundle for the multicycle MIPS-style control unit.
// master = controller side, slave = datapath/memory side.
interface mcycle_control_unit_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [1:0] pc_src_sel;
  logic [1:0] reg_dst_sel;
  logic       alu_src_sel;
  logic [1:0] mem_to_reg_sel;
  logic [1:0] alu_op;
  logic       pc_ld;
  logic       ir_ld;
  logic       rf_ld;
  logic       mem_rd;
  logic       mem_wr;
  logic       illegal;
  logic       err;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_src_sel, reg_dst_sel, alu_src_sel,
    output mem_to_reg_sel, alu_op,
    output pc_ld, ir_ld, rf_ld, mem_rd, mem_wr,
    output illegal, err, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_src_sel, reg_dst_sel, alu_src_sel,
    input  mem_to_reg_sel, alu_op,
    input  pc_ld, ir_ld, rf_ld, mem_rd, mem_wr,
    input  illegal, err, state
  );
endinterface

// File: rtl/mcycle_control_unit.sv
// Multicycle control FSM: fetch/decode/exec/mem/wb sequencing with
// memory-wait timeout that parks the controller in a sticky ERROR state.
module mcycle_control_unit #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  mcycle_control_unit_if.master bus
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_LOAD_IR = 4'd2;
  localparam logic [3:0] S_DECODE  = 4'd3;
  localparam logic [3:0] S_EXEC    = 4'd4;
  localparam logic [3:0] S_MEM     = 4'd5;
  localparam logic [3:0] S_WB      = 4'd6;
  localparam logic [3:0] S_ERROR   = 4'd7;

  localparam logic [3:0] C_R    = 4'd0;
  localparam logic [3:0] C_JR   = 4'd1;
  localparam logic [3:0] C_ADDI = 4'd2;
  localparam logic [3:0] C_LW   = 4'd3;
  localparam logic [3:0] C_SW   = 4'd4;
  localparam logic [3:0] C_BEQ  = 4'd5;
  localparam logic [3:0] C_J    = 4'd6;
  localparam logic [3:0] C_JAL  = 4'd7;
  localparam logic [3:0] C_ILL  = 4'd8;

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] W_LAST = CW'(WAIT_LIMIT - 1);

  logic [3:0]    r_state;
  logic [3:0]    w_next;
  logic [5:0]    r_op;
  logic [5:0]    r_fn;
  logic [CW-1:0] r_wait;
  logic [3:0]    w_dec_cls;
  logic [3:0]    w_cls;
  logic          w_wait_st;

  logic [1:0] w_pc_src;
  logic [1:0] w_reg_dst;
  logic       w_alu_src;
  logic [1:0] w_m2r;
  logic [1:0] w_alu_op;
  logic       w_pc_ld;
  logic       w_ir_ld;
  logic       w_rf_ld;
  logic       w_mem_rd;
  logic       w_mem_wr;
  logic       w_illegal;
  logic       w_err;

  function automatic logic [3:0] classify(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    logic [3:0] c;
    c = C_ILL;
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h22, 6'h24,
          6'h25, 6'h2A: c = C_R;
          6'h08:        c = C_JR;
          default:      c = C_ILL;
        endcase
      end
      6'h08:   c = C_ADDI;
      6'h23:   c = C_LW;
      6'h2B:   c = C_SW;
      6'h04:   c = C_BEQ;
      6'h02:   c = C_J;
      6'h03:   c = C_JAL;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  // DECODE judges the live IR; later states use the latched copy.
  assign w_dec_cls = classify(bus.opcode, bus.funct);
  assign w_cls     = classify(r_op, r_fn);
  assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEM);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    w_next = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready)        w_next = S_LOAD_IR;
        else if (r_wait == W_LAST) w_next = S_ERROR;
      end
      S_LOAD_IR: w_next = S_DECODE;
      S_DECODE:
        w_next = (w_dec_cls == C_ILL) ? S_FETCH : S_EXEC;
      S_EXEC: begin
        case (w_cls)
          C_R, C_ADDI: w_next = S_WB;
          C_LW, C_SW:  w_next = S_MEM;
          default:     w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready)
          w_next = (w_cls == C_LW) ? S_WB : S_FETCH;
        else if (r_wait == W_LAST)
          w_next = S_ERROR;
      end
      S_WB:      w_next = S_FETCH;
      S_ERROR:   w_next = S_ERROR;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_op    <= '0;
      r_fn    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op <= bus.opcode;
        r_fn <= bus.funct;
      end
      if (w_next != r_state &&
          (w_next == S_FETCH || w_next == S_MEM))
        r_wait <= '0;
      else if (w_wait_st && !bus.mem_ready)
        r_wait <= r_wait + 1'b1;
    end
  end

  always_comb begin
    w_pc_src  = 2'b00;
    w_reg_dst = 2'b00;
    w_alu_src = 1'b0;
    w_m2r     = 2'b00;
    w_alu_op  = 2'b00;
    w_pc_ld   = 1'b0;
    w_ir_ld   = 1'b0;
    w_rf_ld   = 1'b0;
    w_mem_rd  = 1'b0;
    w_mem_wr  = 1'b0;
    w_illegal = 1'b0;
    w_err     = 1'b0;
    unique case (r_state)
      S_FETCH:   w_mem_rd = 1'b1;
      S_LOAD_IR: begin
        w_ir_ld = 1'b1;
        w_pc_ld = 1'b1;
      end
      S_DECODE:  w_illegal = (w_dec_cls == C_ILL);
      S_EXEC: begin
        case (w_cls)
          C_R: w_alu_op = 2'b10;
          C_ADDI, C_LW, C_SW: w_alu_src = 1'b1;
          C_BEQ: begin
            w_alu_op = 2'b01;
            w_pc_src = 2'b01;
            w_pc_ld  = bus.zero;
          end
          C_J: begin
            w_pc_ld  = 1'b1;
            w_pc_src = 2'b10;
          end
          C_JAL: begin
            w_pc_ld   = 1'b1;
            w_pc_src  = 2'b10;
            w_rf_ld   = 1'b1;
            w_reg_dst = 2'b10;
            w_m2r     = 2'b10;
          end
          C_JR: begin
            w_pc_ld  = 1'b1;
            w_pc_src = 2'b11;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_mem_rd = (w_cls == C_LW);
        w_mem_wr = (w_cls == C_SW);
      end
      S_WB: begin
        w_rf_ld   = 1'b1;
        w_reg_dst = (w_cls == C_R) ? 2'b01 : 2'b00;
        w_m2r     = (w_cls == C_LW) ? 2'b01 : 2'b00;
      end
      S_ERROR:   w_err = 1'b1;
      default: ;
    endcase
  end

  assign bus.pc_src_sel     = w_pc_src;
  assign bus.reg_dst_sel    = w_reg_dst;
  assign bus.alu_src_sel    = w_alu_src;
  assign bus.mem_to_reg_sel = w_m2r;
  assign bus.alu_op         = w_alu_op;
  assign bus.pc_ld          = w_pc_ld;
  assign bus.ir_ld          = w_ir_ld;
  assign bus.rf_ld          = w_rf_ld;
  assign bus.mem_rd         = w_mem_rd;
  assign bus.mem_wr         = w_mem_wr;
  assign bus.illegal        = w_illegal;
  assign bus.err            = w_err;
  assign bus.state          = r_state;

endmodule
